// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces N raw push-button inputs and
// turns them into clean levels plus single-cycle press, release and
// long-press events. All outputs are registered in the clk domain.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   key_raw[N]   raw, bouncy, asynchronous button inputs (1 = pressed)
//   key_level[N] debounced key state (1 = pressed)
//   key_press[N] 1-cycle pulse on the cycle key_level rises
//   key_release[N] 1-cycle pulse on the cycle key_level falls
//   key_long[N]  1-cycle pulse, once per press, after LONG_CYCLES held

module key_debounce_lane #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);
    localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);

    // Bit 1 of the encoding is the debounced level, bit 0 means "counting".
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ARMING_HI = 2'b01,
        HELD      = 2'b10,
        ARMING_LO = 2'b11
    } state_t;

    state_t      state, state_nxt;
    logic        sync1, sync2;
    logic [31:0] cnt, cnt_nxt;
    logic [31:0] hold, hold_nxt;
    logic        fired, fired_nxt;
    logic        press_nxt, release_nxt, long_nxt;

    assign key_level = state[1];

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hold_nxt    = hold;
        fired_nxt   = fired;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;

        // Debounce: any sample equal to the current level restarts the count.
        if (sync2 == state[1]) begin
            cnt_nxt   = '0;
            state_nxt = state[1] ? HELD : IDLE;
        end else if (cnt == DB_LAST) begin
            cnt_nxt     = '0;
            state_nxt   = sync2 ? HELD : IDLE;
            press_nxt   = sync2;
            release_nxt = ~sync2;
        end else begin
            cnt_nxt   = cnt + 32'd1;
            state_nxt = state[1] ? ARMING_LO : ARMING_HI;
        end

        // Long-press: runs on the registered level, so counting starts the
        // edge after the press. A release on the terminal edge wins.
        if (!state[1]) begin
            hold_nxt  = '0;
            fired_nxt = 1'b0;
        end else if (!fired) begin
            if (hold == LONG_LAST) begin
                if (!release_nxt) begin
                    long_nxt  = 1'b1;
                    fired_nxt = 1'b1;
                end
            end else begin
                hold_nxt = hold + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            cnt         <= '0;
            hold        <= '0;
            fired       <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_nxt;
            sync1       <= key_raw;
            sync2       <= sync1;
            cnt         <= cnt_nxt;
            hold        <= hold_nxt;
            fired       <= fired_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_long    <= long_nxt;
        end
    end
endmodule

module key_debounce #(
    parameter int          N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key_raw,
    output logic [N-1:0] key_level,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release,
    output logic [N-1:0] key_long
);
    for (genvar i = 0; i < N; i++) begin : g_key
        key_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .key_raw    (key_raw[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i])
        );
    end
endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce (N=4, DEBOUNCE_CYCLES=8,
// LONG_CYCLES=20). Edge numbering: inputs change #1 after a rising edge;
// "edge k" is the k-th rising edge after the change, sampled #1 later.

module tb_key_debounce;
    localparam int N  = 4;
    localparam int DB = 8;
    localparam int LC = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key_raw = '0;
    logic [N-1:0] key_level, key_press, key_release, key_long;

    int checks = 0;
    int errors = 0;

    key_debounce #(.N(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        key_raw = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        key_raw = 4'hf;
        rst = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({key_level, key_press, key_release, key_long} !== 16'h0) begin
            errors++;
            $display("FAIL reset: got lvl=%h prs=%h rel=%h lng=%h, want all 0",
                     key_level, key_press, key_release, key_long);
        end
        do_reset();
        checks++;
        if ({key_level, key_press, key_release, key_long} !== 16'h0) begin
            errors++;
            $display("FAIL reset_release: got lvl=%h prs=%h rel=%h lng=%h, want all 0",
                     key_level, key_press, key_release, key_long);
        end
    endtask

    task automatic test_clean_press;
        logic [N-1:0] el, ep;
        do_reset();
        key_raw[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            el = (e >= 10) ? 4'h1 : 4'h0;
            ep = (e == 10) ? 4'h1 : 4'h0;
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {el, ep, 8'h00}) begin
                errors++;
                $display("FAIL clean_press e=%0d: got lvl=%h prs=%h rel=%h lng=%h, want lvl=%h prs=%h",
                         e, key_level, key_press, key_release, key_long, el, ep);
            end
        end
    endtask

    task automatic test_bounce;
        logic [N-1:0] el, ep;
        do_reset();
        for (int seg = 0; seg < 10; seg++) begin
            key_raw[1] = (seg % 2 == 0);
            for (int k = 0; k < 3; k++) begin
                tick();
                checks++;
                if ({key_level, key_press, key_release, key_long} !== 16'h0) begin
                    errors++;
                    $display("FAIL bounce seg=%0d k=%0d: got lvl=%h prs=%h rel=%h lng=%h, want all 0",
                             seg, k, key_level, key_press, key_release, key_long);
                end
            end
        end
        key_raw[1] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            el = (e >= 10) ? 4'h2 : 4'h0;
            ep = (e == 10) ? 4'h2 : 4'h0;
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {el, ep, 8'h00}) begin
                errors++;
                $display("FAIL bounce_settle e=%0d: got lvl=%h prs=%h rel=%h lng=%h, want lvl=%h prs=%h",
                         e, key_level, key_press, key_release, key_long, el, ep);
            end
        end
    endtask

    // Press at 10, 5-cycle low glitch (raw low after edges 12..17),
    // long at 30, raw released after edge 25 -> release at 35.
    task automatic test_release;
        logic [N-1:0] el, ep, er, eg;
        do_reset();
        key_raw[0] = 1'b1;
        for (int e = 1; e <= 37; e++) begin
            tick();
            el = (e >= 10 && e < 35) ? 4'h1 : 4'h0;
            ep = (e == 10) ? 4'h1 : 4'h0;
            er = (e == 35) ? 4'h1 : 4'h0;
            eg = (e == 30) ? 4'h1 : 4'h0;
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {el, ep, er, eg}) begin
                errors++;
                $display("FAIL release e=%0d: got lvl=%h prs=%h rel=%h lng=%h, want lvl=%h prs=%h rel=%h lng=%h",
                         e, key_level, key_press, key_release, key_long, el, ep, er, eg);
            end
            if (e == 12) key_raw[0] = 1'b0;
            if (e == 17) key_raw[0] = 1'b1;
            if (e == 25) key_raw[0] = 1'b0;
        end
    endtask

    // rel_edge: edge at which release is expected (raw drops 10 edges earlier).
    task automatic test_long_press(input int rel_edge, input int last, input int long_edge);
        logic [N-1:0] el, ep, er, eg;
        do_reset();
        key_raw[2] = 1'b1;
        for (int e = 1; e <= last; e++) begin
            tick();
            el = (e >= 10 && e < rel_edge) ? 4'h4 : 4'h0;
            ep = (e == 10) ? 4'h4 : 4'h0;
            er = (e == rel_edge) ? 4'h4 : 4'h0;
            eg = (e == long_edge) ? 4'h4 : 4'h0;
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {el, ep, er, eg}) begin
                errors++;
                $display("FAIL long_press rel=%0d e=%0d: got lvl=%h prs=%h rel=%h lng=%h, want lvl=%h prs=%h rel=%h lng=%h",
                         rel_edge, e, key_level, key_press, key_release, key_long, el, ep, er, eg);
            end
            if (e == rel_edge - 10) key_raw[2] = 1'b0;
        end
    endtask

    task automatic test_simultaneous;
        logic [N-1:0] el, ep;
        do_reset();
        key_raw = 4'hf;
        for (int e = 1; e <= 12; e++) begin
            tick();
            el = (e >= 10) ? 4'hf : 4'h0;
            ep = (e == 10) ? 4'hf : 4'h0;
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {el, ep, 8'h00}) begin
                errors++;
                $display("FAIL simultaneous e=%0d: got lvl=%h prs=%h rel=%h lng=%h, want lvl=%h prs=%h",
                         e, key_level, key_press, key_release, key_long, el, ep);
            end
        end
        do_reset();
        key_raw = 4'h7;
        for (int e = 1; e <= 14; e++) begin
            tick();
            el = ((e >= 10) ? 4'h7 : 4'h0) | ((e >= 12) ? 4'h8 : 4'h0);
            ep = ((e == 10) ? 4'h7 : 4'h0) | ((e == 12) ? 4'h8 : 4'h0);
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {el, ep, 8'h00}) begin
                errors++;
                $display("FAIL staggered e=%0d: got lvl=%h prs=%h rel=%h lng=%h, want lvl=%h prs=%h",
                         e, key_level, key_press, key_release, key_long, el, ep);
            end
            if (e == 2) key_raw[3] = 1'b1;
        end
    endtask

    // Reset asserted after edge rst_edge; raw[0] stays high throughout, so
    // the key re-presses 10 edges after rst drops and long fires 20 later.
    task automatic test_reset_mid(input int rst_edge);
        logic [N-1:0] el, ep, eg;
        do_reset();
        key_raw[0] = 1'b1;
        for (int e = 1; e <= rst_edge; e++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({key_level, key_press, key_release, key_long} !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid at=%0d: got lvl=%h prs=%h rel=%h lng=%h, want all 0",
                     rst_edge, key_level, key_press, key_release, key_long);
        end
        rst = 1'b0;
        for (int e = 1; e <= 31; e++) begin
            tick();
            el = (e >= 10) ? 4'h1 : 4'h0;
            ep = (e == 10) ? 4'h1 : 4'h0;
            eg = (e == 30) ? 4'h1 : 4'h0;
            checks++;
            if ({key_level, key_press, key_release, key_long} !== {el, ep, 4'h0, eg}) begin
                errors++;
                $display("FAIL reset_mid_after at=%0d e=%0d: got lvl=%h prs=%h rel=%h lng=%h, want lvl=%h prs=%h lng=%h",
                         rst_edge, e, key_level, key_press, key_release, key_long, el, ep, eg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_long_press(60, 62, 30);  // held 40 past press: one pulse at P+20
        test_long_press(25, 45, 0);   // released at P+15: no long
        test_long_press(30, 35, 0);   // release on terminal edge: release wins
        test_simultaneous();
        test_reset_mid(7);            // debounce count at 5
        test_reset_mid(22);           // hold count at 12
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_debounce.md
# key_debounce

Input-side companion to the board LED drivers: synchronizes and debounces N raw push-button inputs and turns them into clean levels plus single-cycle press, release and long-press events. User-interface logic consumes these events, e.g. start/stop, direction or speed select for LED patterns. All outputs are registered in the clk domain.

## Interface
- N, default 4: number of independent keys.
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range 1..2^32-1.
- LONG_CYCLES, default 50000000: cycles a key must stay debounced-high to raise a long-press event (1 s at 50 MHz); legal range 1..2^32-1.
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- key_raw  input  N  raw button inputs, active-high, asynchronous to clk, bouncy.
- key_level  output  N  debounced key state, 1 = pressed.
- key_press  output  N  1-cycle pulse on the cycle key_level rises.
- key_release  output  N  1-cycle pulse on the cycle key_level falls.
- key_long  output  N  1-cycle pulse, at most once per press, after LONG_CYCLES of held level.

## Operation
- Per key, fully independent; no cross-key interaction.
- Synchronizer: two flops, sync1 <= key_raw, sync2 <= sync1. Only sync2 feeds the debounce logic.
- Debounce counter: 32-bit, one per key.
  - Edge with sync2 == key_level: counter <= 0, level unchanged.
  - Edge with sync2 != key_level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - Edge with sync2 != key_level and counter == DEBOUNCE_CYCLES-1: key_level <= sync2, counter <= 0.
  - Any glitch back to the current level restarts the count from 0.
- Event pulses are registered and are high only for the edge at which key_level toggles:
  - key_press on a 0->1 toggle.
  - key_release on a 1->0 toggle.
- Long-press: 32-bit hold counter plus a fired flag, one of each per key.
  - While key_level == 0: hold counter = 0, fired = 0, key_long = 0.
  - While key_level == 1 and fired == 0: hold counter increments each edge.
  - When the hold counter reaches LONG_CYCLES-1 (key_level still 1), key_long pulses for that edge and fired <= 1. No further key_long until release.
  - Hold counting starts on the edge after the press edge.
- Per-key state view: IDLE (level 0, stable), ARMING_HI (level 0, counting), HELD (level 1, stable), ARMING_LO (level 1, counting).
  - IDLE->ARMING_HI when sync2 = 1.
  - ARMING_HI->IDLE on sync2 = 0.
  - ARMING_HI->HELD on count completion.
  - HELD and ARMING_LO behave symmetrically.
  - The hold counter keeps running through ARMING_LO.

## Timing
- Reset values: all outputs 0; sync flops 0; all counters 0; fired 0. Reset overrides everything on the same edge, including mid-count and mid-hold.
- After reset release with a key already held: treated as a fresh press. key_press fires DEBOUNCE_CYCLES+2 edges later.
- Press latency: key_raw rises before edge 1 and stays stable. sync2 = 1 after edge 2. key_level and key_press go high at edge DEBOUNCE_CYCLES+2.
- Release latency is symmetric: DEBOUNCE_CYCLES+2 edges.
- key_long is high at edge P+LONG_CYCLES, where P is the press edge.
- If the release toggle edge coincides with the long-press terminal count, key_release fires and key_long does not.
- DEBOUNCE_CYCLES = 1: a single stable differing sample toggles the level, giving 3-edge latency.
- Counters never wrap. The debounce counter is bounded by DEBOUNCE_CYCLES-1; the hold counter stops once fired.

## Test plan
Bench parameters: N=4, DEBOUNCE_CYCLES=8, LONG_CYCLES=20.

1. **Clean press.** key_raw[0] 0->1 before edge 1, held -> key_level[0] and key_press[0] high at edge 10. key_press is low at edge 11. Other keys stay 0.
2. **Bounce rejection.** key_raw[1] toggles every 3 cycles for 30 cycles, then stays 1 -> no key_press during bouncing. A single key_press[1] occurs 10 edges after the last transition.
3. **Release.** Key 0 is held, then key_raw[0] 1->0 -> key_release[0] pulses 10 edges later and key_level[0] returns to 0. The glitch case: a 5-cycle low pulse mid-hold gives no release.
4. **Long press.** Key 2 is held 40 cycles after its press edge P -> key_long[2] is a single pulse at P+20, with no second pulse. Released at P+15 instead -> no key_long.
5. **Simultaneous keys.** All four keys rise together -> all key_press bits pulse on the same edge, 10. Staggering key 3 by 2 cycles -> its pulse is 2 edges later.
6. **Reset mid-operation.** Assert rst at debounce count 5, and separately mid-hold at hold count 12 -> all outputs and counters are 0 on the next edge. With key_raw still high after release, key_press fires 10 edges after rst deasserts.
